// File: rtl/ultrasonic_scheduler_if.sv
// Result handshake carrying one ranging measurement from the scheduler to its consumer.
interface ultrasonic_scheduler_if #(
  parameter int RANGE_WIDTH = 24,
  parameter int ID_W        = 2
);
  logic                   range_valid;
  logic                   range_ready;
  logic [RANGE_WIDTH-1:0] range_data;
  logic [ID_W-1:0]        range_id;
  logic                   range_timeout;

  modport master (
    output range_valid,
    output range_data,
    output range_id,
    output range_timeout,
    input  range_ready
  );

  modport slave (
    input  range_valid,
    input  range_data,
    input  range_id,
    input  range_timeout,
    output range_ready
  );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Round-robin ultrasonic ping scheduler: triggers one sensor at a time, times its echo
// with a shared counter and hands each result out over a valid/ready handshake.
module ultrasonic_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int RANGE_WIDTH    = 24,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GAP_CYCLES     = 3000000,
  parameter int ID_W           = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [N_SENSORS-1:0]   echo,
  output logic [N_SENSORS-1:0]   trigger,
  output logic                   busy,
  ultrasonic_scheduler_if.master res
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRIG      = 3'd1;
  localparam logic [2:0] S_WAIT_RISE = 3'd2;
  localparam logic [2:0] S_MEASURE   = 3'd3;
  localparam logic [2:0] S_REPORT    = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;

  localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]   CH_LAST   = ID_W'(N_SENSORS - 1);

  logic [2:0]             state;
  logic [ID_W-1:0]        ch;
  logic [ID_W-1:0]        ch_next;
  logic [TRIG_W-1:0]      trig_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [RANGE_WIDTH-1:0] width_cnt;

  logic [N_SENSORS-1:0]   echo_p0;
  logic [N_SENSORS-1:0]   echo_p1;
  logic [N_SENSORS-1:0]   echo_p2;
  logic                   echo_sel;
  logic                   echo_rise;

  logic [N_SENSORS-1:0]   trigger_q;
  logic                   valid_q;
  logic [RANGE_WIDTH-1:0] data_q;
  logic [ID_W-1:0]        id_q;
  logic                   timeout_q;

  function automatic logic [RANGE_WIDTH-1:0] sat_inc(input logic [RANGE_WIDTH-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + RANGE_WIDTH'(1);
  endfunction

  function automatic logic [N_SENSORS-1:0] onehot(input logic [ID_W-1:0] c);
    onehot    = '0;
    onehot[c] = 1'b1;
  endfunction

  // Only the selected channel is ever looked at; p2 is the previous settled sample.
  assign echo_sel  = echo_p1[ch];
  assign echo_rise = echo_p1[ch] & ~echo_p2[ch];
  assign ch_next   = (ch == CH_LAST) ? '0 : ch + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ch        <= '0;
      trig_cnt  <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      width_cnt <= '0;
      echo_p0   <= '0;
      echo_p1   <= '0;
      echo_p2   <= '0;
      trigger_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      id_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      // stage p0/p1: two-flop synchronizer, stage p2: edge history
      echo_p0 <= echo;
      echo_p1 <= echo_p0;
      echo_p2 <= echo_p1;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state     <= S_TRIG;
            trig_cnt  <= '0;
            trigger_q <= onehot(ch);
          end
        end

        S_TRIG: begin
          if (trig_cnt == TRIG_LAST) begin
            state     <= S_WAIT_RISE;
            trigger_q <= '0;
            tmo_cnt   <= '0;
          end else begin
            trig_cnt <= trig_cnt + TRIG_W'(1);
          end
        end

        S_WAIT_RISE: begin
          if (tmo_cnt == TMO_LAST) begin
            state     <= S_REPORT;
            valid_q   <= 1'b1;
            data_q    <= '1;
            id_q      <= ch;
            timeout_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (echo_rise) begin
              state     <= S_MEASURE;
              width_cnt <= RANGE_WIDTH'(1);
            end
          end
        end

        S_MEASURE: begin
          // A fall on the final timeout cycle still counts as a real measurement.
          if (!echo_sel) begin
            state     <= S_REPORT;
            valid_q   <= 1'b1;
            data_q    <= width_cnt;
            id_q      <= ch;
            timeout_q <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= S_REPORT;
            valid_q   <= 1'b1;
            data_q    <= '1;
            id_q      <= ch;
            timeout_q <= 1'b1;
          end else begin
            tmo_cnt   <= tmo_cnt + TMO_W'(1);
            width_cnt <= sat_inc(width_cnt);
          end
        end

        S_REPORT: begin
          if (valid_q && res.range_ready) begin
            state   <= S_GAP;
            valid_q <= 1'b0;
            gap_cnt <= '0;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            ch <= ch_next;
            if (enable) begin
              state     <= S_TRIG;
              trig_cnt  <= '0;
              trigger_q <= onehot(ch_next);
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign trigger           = trigger_q;
  assign busy              = (state != S_IDLE);
  assign res.range_valid   = valid_q;
  assign res.range_data    = data_q;
  assign res.range_id      = id_q;
  assign res.range_timeout = timeout_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Scoreboard bench for ultrasonic_scheduler: randomized echo pings against a timeline model,
// plus a second instance with a long timeout to exercise width saturation.
module tb_ultrasonic_scheduler;
  localparam int N    = 4;
  localparam int RW   = 8;
  localparam int TRIG = 4;
  localparam int TMO  = 50;
  localparam int GAP  = 10;
  localparam int TMO2 = 400;
  localparam int MAXV = (1 << RW) - 1;

  typedef struct {
    int id;
    int data;
    int to;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, enable, busy;
  logic [N-1:0] echo, trigger;
  logic         rst2, en2, busy2;
  logic [N-1:0] echo2, trig2;

  ultrasonic_scheduler_if #(.RANGE_WIDTH(RW), .ID_W(2)) rif ();
  ultrasonic_scheduler_if #(.RANGE_WIDTH(RW), .ID_W(2)) rif2 ();

  ultrasonic_scheduler #(
    .N_SENSORS(N), .RANGE_WIDTH(RW), .TRIG_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP), .ID_W(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo),
    .trigger(trigger), .busy(busy), .res(rif)
  );

  ultrasonic_scheduler #(
    .N_SENSORS(N), .RANGE_WIDTH(RW), .TRIG_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TMO2), .GAP_CYCLES(GAP), .ID_W(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .enable(en2), .echo(echo2),
    .trigger(trig2), .busy(busy2), .res(rif2)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   exp_ch = 0;
  int   stall_req = 0;
  int   stall_left = 0;
  bit   dut2_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic bound_expired(input string name, input int limit);
    checks++;
    errors++;
    $display("FAIL %s: no response within %0d cycles", name, limit);
    finish_run();
  endtask

  function automatic logic [N-1:0] oh(input int c);
    oh    = '0;
    oh[c] = 1'b1;
  endfunction

  // Expected result from the echo timeline: the DUT sees the echo two cycles late,
  // cycle 0 is the first cycle with trigger low, and the ping times out once the
  // synchronized fall would land on or after cycle TMO.
  function automatic exp_t model(input int id, input bit pre, input int d, input int l,
                                 input int h, input int tmo);
    exp_t e;
    int   start, fall;
    start = pre ? d + l : d;
    fall  = start + h + 2;
    e.id  = id;
    if (h == 0 || fall >= tmo) begin
      e.data = MAXV; e.to = 1; e.lat = tmo;
    end else begin
      e.data = (h > MAXV) ? MAXV : h; e.to = 0; e.lat = fall + 1;
    end
    return e;
  endfunction

  task automatic wait_trigger(input bit level, input int limit, input string name);
    int n = 0;
    while (((trigger != '0) != level) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if ((trigger != '0) != level) bound_expired(name, limit);
  endtask

  task automatic run_ping(input bit pre, input int d, input int l, input int h,
                          input int stall, input bit drop_en);
    int           start, t_end, n;
    logic [N-1:0] sel;
    stall_req = stall;
    wait_trigger(1'b1, 300, "trig_start");
    sel = oh(exp_ch);
    check("trig_onehot", int'(trigger), int'(sel));
    if (pre) echo = sel;
    sb_q.push_back(model(exp_ch, pre, d, l, h, TMO));
    wait_trigger(1'b0, TRIG + 2, "trig_end");
    start = pre ? d + l : d;
    t_end = start + h;
    for (int t = 0; t <= t_end; t++) begin
      logic lvl;
      lvl  = (pre && t < d) || (t >= start && t < start + h);
      echo = (N'($urandom) & ~sel) | (lvl ? sel : '0);
      if (drop_en && t == 1) enable = 1'b0;
      @(posedge clk); #1;
    end
    echo   = '0;
    exp_ch = (exp_ch + 1) % N;
    if (drop_en) begin
      n = 0;
      while (busy && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (busy) bound_expired("idle_after_drop", 200);
      repeat (5) @(posedge clk);
      #1;
      check("idle_trigger", int'(trigger), 0);
      check("idle_busy", int'(busy), 0);
      enable = 1'b1;
    end
  endtask

  // Consumer: stalls the requested number of cycles once a result appears.
  initial begin
    rif.range_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rif.range_valid) begin
        rif.range_ready = 1'($urandom_range(0, 1));
        stall_left      = stall_req;
      end else if (stall_left > 0) begin
        rif.range_ready = 1'b0;
        stall_left--;
      end else begin
        rif.range_ready = 1'b1;
      end
    end
  end

  // Monitor: trigger pulse shape, result latency, hold stability and scoreboard pops.
  int           cyc, fall_cyc, lat, trig_len;
  logic [N-1:0] trig_val, prev_trig;
  bit           prev_vld, prev_rdy, trig_bad;
  int           h_data, h_id, h_to;
  initial begin
    exp_t e;
    cyc = 0; fall_cyc = 0; lat = 0; trig_len = 0;
    trig_val = '0; prev_trig = '0; prev_vld = 0; prev_rdy = 0; trig_bad = 0;
    h_data = 0; h_id = 0; h_to = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_trig = '0; prev_vld = 0; prev_rdy = 0; trig_len = 0; trig_bad = 0;
      end else begin
        if (trigger != '0) begin
          if (prev_trig == '0) begin
            trig_len = 1;
            trig_val = trigger;
          end else begin
            trig_len++;
            if (trigger != trig_val) trig_bad = 1;
          end
        end else if (prev_trig != '0) begin
          check("trig_len", trig_len, TRIG);
          check("trig_steady", int'(trig_bad), 0);
          trig_bad = 0;
          fall_cyc = cyc;
        end
        prev_trig = trigger;

        if (rif.range_valid && !prev_vld) lat = cyc - fall_cyc;

        if (prev_vld && !prev_rdy) begin
          check("hold_valid", int'(rif.range_valid), 1);
          check("hold_data", int'(rif.range_data), h_data);
          check("hold_id", int'(rif.range_id), h_id);
          check("hold_timeout", int'(rif.range_timeout), h_to);
        end

        if (rif.range_valid && rif.range_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: result id %0d data %0d with no ping outstanding",
                     rif.range_id, rif.range_data);
          end else begin
            e = sb_q.pop_front();
            check("res_id", int'(rif.range_id), e.id);
            check("res_data", int'(rif.range_data), e.data);
            check("res_timeout", int'(rif.range_timeout), e.to);
            check("res_latency", lat, e.lat);
          end
        end
        prev_vld = rif.range_valid;
        prev_rdy = rif.range_ready;
        h_data   = int'(rif.range_data);
        h_id     = int'(rif.range_id);
        h_to     = int'(rif.range_timeout);
      end
    end
  end

  // Main stimulus.
  initial begin
    logic [N-1:0] sel;
    int           n;
    rst = 1'b1; enable = 1'b0; echo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trigger", int'(trigger), 0);
    check("rst_valid", int'(rif.range_valid), 0);
    check("rst_data", int'(rif.range_data), 0);
    check("rst_id", int'(rif.range_id), 0);
    check("rst_timeout", int'(rif.range_timeout), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1; exp_ch = 0;

    run_ping(0, 20, 0, 12, 0, 0);
    run_ping(0, 0, 0, 0, 0, 0);
    run_ping(0, 10, 0, 8, 7, 0);
    run_ping(1, 3, 3, 5, 0, 0);
    run_ping(0, 20, 0, 27, 1, 0);
    run_ping(0, 20, 0, 28, 0, 0);
    run_ping(0, 4, 0, 6, 2, 1);
    for (int i = 0; i < 16; i++) begin
      bit pre;
      int d, l, h;
      pre = ($urandom_range(0, 3) == 0);
      d   = $urandom_range(0, 30);
      l   = $urandom_range(1, 5);
      h   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
      run_ping(pre, d, l, h, $urandom_range(0, 3), 0);
    end

    stall_req = 0;
    wait_trigger(1'b1, 300, "trig_rst_ping");
    sel = oh(exp_ch);
    check("trig_onehot", int'(trigger), int'(sel));
    wait_trigger(1'b0, TRIG + 2, "trig_end");
    echo = sel;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_trigger", int'(trigger), 0);
    check("midrst_valid", int'(rif.range_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_data", int'(rif.range_data), 0);
    @(posedge clk); #1;
    rst = 1'b0; echo = '0; exp_ch = 0;
    run_ping(0, 5, 0, 6, 0, 0);

    n = 0;
    while ((sb_q.size() != 0 || !dut2_done) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("sb_drained", sb_q.size(), 0);
    check("sat_done", int'(dut2_done), 1);
    finish_run();
  end

  // Long-timeout instance: an echo held far beyond the counter range saturates.
  initial begin
    int n;
    rst2 = 1'b1; en2 = 1'b0; echo2 = '0; rif2.range_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst2 = 1'b0; en2 = 1'b1;
    n = 0;
    while (trig2 == '0 && n < 50) begin @(posedge clk); #1; n++; end
    if (trig2 == '0) bound_expired("sat_trig_start", 50);
    check("sat_trig", int'(trig2), 1);
    en2 = 1'b0;
    n = 0;
    while (trig2 != '0 && n < 10) begin @(posedge clk); #1; n++; end
    if (trig2 != '0) bound_expired("sat_trig_end", 10);
    echo2 = 4'b0001;
    repeat (300) @(posedge clk);
    #1;
    echo2 = '0;
    n = 0;
    while (!rif2.range_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!rif2.range_valid) bound_expired("sat_valid", 20);
    @(negedge clk);
    check("sat_data", int'(rif2.range_data), MAXV);
    check("sat_timeout", int'(rif2.range_timeout), 0);
    check("sat_id", int'(rif2.range_id), 0);
    dut2_done = 1'b1;
  end

  initial begin
    #400000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    finish_run();
  end

endmodule
